// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: bus word, RAM handshake states and the
// memory-arbiter state encoding, plus the arbiter's request-selection rule.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Handshake state reported by the RAM model
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Memory arbiter FSM states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DACC   = 3'd1,
        IACC   = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } arb_state_t;

    // Picks the next access from IDLE. Data normally wins, but right after a
    // data response a waiting fetch goes first so fetch can never starve.
    function automatic arb_state_t idle_select(input logic d_req,
                                               input logic i_req,
                                               input logic last_was_d);
        arb_state_t sel;
        if (d_req && !(i_req && last_was_d)) begin
            sel = DACC;
        end else if (i_req) begin
            sel = IACC;
        end else begin
            sel = IDLE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: step on inc unless already at the all-ones ceiling
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register, cleared by the asynchronous reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one single-ported RAM between instruction fetch
// and data accesses, returns load data and raises the ihit/dhit strobes
// that advance the pipeline. Data has priority; after a data response a
// pending fetch is served first. Stalled accesses time out into a sticky
// error flag and the requester simply retries.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             iREN,
    input  logic [31:0]      iaddr,
    input  logic             dREN,
    input  logic             dWEN,
    input  logic [31:0]      daddr,
    input  logic [31:0]      dstore,
    output logic             ihit,
    output logic             dhit,
    output logic [31:0]      iload,
    output logic [31:0]      dload,
    output logic             ramREN,
    output logic             ramWEN,
    output logic [31:0]      ramaddr,
    output logic [31:0]      ramstore,
    input  logic [31:0]      ramload,
    input  logic [1:0]       ramstate,
    output logic             mem_err,
    output logic [CNT_W-1:0] ihit_cnt,
    output logic [CNT_W-1:0] dhit_cnt
);

    // Wait counter is wide enough to hold TIMEOUT itself
    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);

    arb_state_t        state_q,      state_d;
    logic [WAIT_W-1:0] wait_q,       wait_d;
    logic              last_was_d_q, last_was_d_d;
    logic              mem_err_q,    mem_err_d;
    logic              ihit_q,       ihit_d;
    logic              dhit_q,       dhit_d;
    word_t             iload_q,      iload_d;
    word_t             dload_q,      dload_d;

    ramstate_t         ram_st_s;
    logic [WAIT_W-1:0] wait_inc_s;
    logic              d_req_s;
    logic              d_read_s;
    logic              ram_ren_s;
    logic              ram_wen_s;
    word_t             ram_addr_s;
    word_t             ram_store_s;

    assign ram_st_s   = ramstate_t'(ramstate);
    assign wait_inc_s = wait_q + WAIT_W'(1);
    assign d_req_s    = dREN | dWEN;
    // A write wins when both data enables are up, so only pure reads load
    assign d_read_s   = dREN & ~dWEN;

    // State, wait counter, flags, load buffers and hit strobes
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            last_was_d_q <= 1'b0;
            mem_err_q    <= 1'b0;
            ihit_q       <= 1'b0;
            dhit_q       <= 1'b0;
            iload_q      <= 32'h0000_0000;
            dload_q      <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            last_was_d_q <= last_was_d_d;
            mem_err_q    <= mem_err_d;
            ihit_q       <= ihit_d;
            dhit_q       <= dhit_d;
            iload_q      <= iload_d;
            dload_q      <= dload_d;
        end
    end

    // Next state: request selection, completion, abort and timeout handling
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        last_was_d_d = last_was_d_q;
        mem_err_d    = mem_err_q;
        iload_d      = iload_q;
        dload_d      = dload_q;
        case (state_q)
            IDLE: begin
                // Counter starts from zero on every entry into an access
                wait_d  = '0;
                state_d = idle_select(d_req_s, iREN, last_was_d_q);
            end
            DACC: begin
                if (!d_req_s) begin
                    state_d = IDLE;
                end else if (ram_st_s == ACCESS) begin
                    if (d_read_s) begin
                        dload_d = ramload;
                    end else begin
                        dload_d = dload_q;
                    end
                    state_d = RESP_D;
                end else if ((ram_st_s == ERROR) || (wait_inc_s == TIMEOUT_C)) begin
                    mem_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wait_d = wait_inc_s;
                end
            end
            IACC: begin
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ram_st_s == ACCESS) begin
                    iload_d = ramload;
                    state_d = RESP_I;
                end else if ((ram_st_s == ERROR) || (wait_inc_s == TIMEOUT_C)) begin
                    mem_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wait_d = wait_inc_s;
                end
            end
            RESP_I: begin
                last_was_d_d = 1'b0;
                state_d      = IDLE;
            end
            RESP_D: begin
                last_was_d_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Hit strobes are registered: high exactly while the FSM sits in RESP_x
    always_comb begin
        ihit_d = (state_d == RESP_I);
        dhit_d = (state_d == RESP_D);
    end

    // RAM drive: only the active access presents address/enables, else all 0
    always_comb begin
        ram_ren_s   = 1'b0;
        ram_wen_s   = 1'b0;
        ram_addr_s  = 32'h0000_0000;
        ram_store_s = 32'h0000_0000;
        case (state_q)
            DACC: begin
                ram_addr_s  = daddr;
                ram_store_s = dstore;
                ram_wen_s   = dWEN;
                ram_ren_s   = d_read_s;
            end
            IACC: begin
                ram_addr_s = iaddr;
                ram_ren_s  = 1'b1;
            end
            default: begin
                ram_ren_s = 1'b0;
            end
        endcase
    end

    assign ramREN   = ram_ren_s;
    assign ramWEN   = ram_wen_s;
    assign ramaddr  = ram_addr_s;
    assign ramstore = ram_store_s;
    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign iload    = iload_q;
    assign dload    = dload_q;
    assign mem_err  = mem_err_q;

    sat_counter #(.W(CNT_W)) u_ihit_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (ihit_q),
        .count (ihit_cnt)
    );

    sat_counter #(.W(CNT_W)) u_dhit_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (dhit_q),
        .count (dhit_cnt)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by a randomized
// phase against a transaction-level model (memory array, requesters that
// hold until their hit, alternation and saturating-count expectations).
module tb_mem_arbiter;

    localparam int TO = 16;
    localparam int CW = 2;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          iREN, dREN, dWEN;
    logic [31:0]   iaddr, daddr, dstore;
    logic          ihit, dhit, ramREN, ramWEN, mem_err;
    logic [31:0]   iload, dload, ramaddr, ramstore, ramload;
    logic [1:0]    ramstate;
    logic [CW-1:0] ihit_cnt, dhit_cnt;

    mem_arbiter #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .mem_err(mem_err), .ihit_cnt(ihit_cnt), .dhit_cnt(dhit_cnt)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:255];

    // RAM model controls
    bit ram_active, rand_lat, stuck, err_mode;
    int wcnt, fixed_lat;

    // Outputs sampled at the falling edge
    logic        s_ihit, s_dhit, s_ren, s_wen, s_err;
    logic [31:0] s_iload, s_dload, s_raddr, s_rstore, s_icnt, s_dcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic int idx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    function automatic logic [31:0] sat(input int c);
        return (c > 3) ? 32'd3 : 32'(c);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [7:0] w;
        w = 8'($urandom);
        return {22'd0, w, 2'b00};
    endfunction

    // One cycle: sample outputs at the falling edge, then respond as the RAM
    task automatic cyc();
        @(negedge CLK);
        s_ihit = ihit;  s_dhit = dhit;  s_ren = ramREN;  s_wen = ramWEN;
        s_err = mem_err; s_iload = iload; s_dload = dload;
        s_raddr = ramaddr; s_rstore = ramstore;
        s_icnt = 32'(ihit_cnt); s_dcnt = 32'(dhit_cnt);
        ramload = $urandom();
        if (ramREN || ramWEN) begin
            if (!ram_active) begin
                ram_active = 1'b1;
                wcnt = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
            end
            if (err_mode) begin
                ramstate = 2'd3;
            end else if (stuck) begin
                ramstate = 2'd1;
            end else if (wcnt == 0) begin
                ramstate = 2'd2;
                if (ramREN) ramload = mem[idx(ramaddr)];
                if (ramWEN) mem[idx(ramaddr)] = ramstore;
            end else begin
                ramstate = 2'd1;
                wcnt--;
            end
        end else begin
            ram_active = 1'b0;
            ramstate   = 2'd0;
        end
    endtask

    task automatic do_reset();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0;
        stuck = 1'b0; err_mode = 1'b0; rand_lat = 1'b0; fixed_lat = 0;
        ram_active = 1'b0; ramstate = 2'd0; ramload = 32'd0;
        nRST = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // Cycle until some hit appears (bounded); n counts cycles from the call
    task automatic wait_hit(input int maxc, output bit gi, output bit gd, output int n);
        gi = 1'b0; gd = 1'b0; n = 0;
        while (!gi && !gd && n < maxc) begin
            cyc();
            n++;
            gi = s_ihit;
            gd = s_dhit;
        end
        chk1("hit_arrived", gi | gd, 1'b1);
        chk1("hit_exclusive", gi & gd, 1'b0);
    endtask

    initial begin
        bit gi, gd, any, ren_at_err;
        int n, mi, md, i_age, d_age, max_age;
        bit i_act, d_act, owed;
        logic [31:0] dl0, exp_dload;

        for (int k = 0; k < 256; k++) mem[k] = $urandom();
        s_err = 1'b0;

        // Reset state
        do_reset();
        #1;
        chk1("rst_ihit", ihit, 1'b0);   chk1("rst_dhit", dhit, 1'b0);
        chk1("rst_ramREN", ramREN, 1'b0); chk1("rst_ramWEN", ramWEN, 1'b0);
        chk("rst_ramaddr", ramaddr, 32'd0); chk("rst_iload", iload, 32'd0);
        chk("rst_dload", dload, 32'd0); chk1("rst_err", mem_err, 1'b0);
        chk("rst_icnt", 32'(ihit_cnt), 32'd0); chk("rst_dcnt", 32'(dhit_cnt), 32'd0);

        // Reset in the middle of a fetch that the RAM keeps BUSY
        iREN = 1'b1; iaddr = 32'h0; stuck = 1'b1;
        cyc(); cyc(); cyc();
        chk1("midrst_driving", s_ren, 1'b1);
        nRST = 1'b0;
        #1;
        chk1("midrst_ramREN", ramREN, 1'b0); chk("midrst_ramaddr", ramaddr, 32'd0);
        chk1("midrst_ihit", ihit, 1'b0);
        iREN = 1'b0; stuck = 1'b0; ram_active = 1'b0; ramstate = 2'd0;
        @(negedge CLK);
        nRST = 1'b1;
        any = 1'b0;
        for (int k = 0; k < 5; k++) begin cyc(); any |= s_ihit | s_ren; end
        chk1("midrst_no_hit", any, 1'b0);
        chk("midrst_icnt", s_icnt, 32'd0);

        // Data read with one BUSY cycle, then a simple fetch
        do_reset();
        dREN = 1'b1; daddr = 32'h20; fixed_lat = 1;
        wait_hit(8, gi, gd, n);
        chk1("rd_is_d", gd, 1'b1); chk("rd_latency", 32'(n), 32'd3);
        chk("rd_dload", s_dload, mem[idx(32'h20)]);
        dl0 = s_dload;
        dREN = 1'b0;
        cyc();
        chk1("rd_strobe_once", s_dhit, 1'b0); chk("rd_dload_hold", s_dload, dl0);
        mem[1] = 32'h8C22_0000;
        iREN = 1'b1; iaddr = 32'h4; fixed_lat = 0;
        wait_hit(8, gi, gd, n);
        chk1("fetch_is_i", gi, 1'b1); chk("fetch_latency", 32'(n), 32'd2);
        chk("fetch_iload", s_iload, 32'h8C22_0000);
        iREN = 1'b0;
        cyc();
        chk("fetch_icnt", s_icnt, 32'd1); chk1("fetch_strobe_once", s_ihit, 1'b0);

        // Simultaneous fetch and data write: write goes first
        iREN = 1'b1; iaddr = 32'h8;
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
        cyc();
        chk1("wr_ramWEN", s_wen, 1'b1); chk1("wr_ramREN", s_ren, 1'b0);
        chk("wr_ramaddr", s_raddr, 32'h100); chk("wr_ramstore", s_rstore, 32'hDEAD_BEEF);
        cyc();
        chk1("wr_dhit", s_dhit, 1'b1); chk1("wr_no_ihit", s_ihit, 1'b0);
        chk("wr_dload_held", s_dload, dl0);
        chk("wr_mem", mem[idx(32'h100)], 32'hDEAD_BEEF);
        dWEN = 1'b0;
        wait_hit(8, gi, gd, n);
        chk1("wr_then_fetch", gi, 1'b1); chk("wr_fetch_iload", s_iload, mem[2]);
        iREN = 1'b0;
        cyc();

        // Alternation with both requests held continuously
        dREN = 1'b1; daddr = 32'h40; iREN = 1'b1; iaddr = 32'hC;
        for (int k = 0; k < 4; k++) begin
            wait_hit(8, gi, gd, n);
            chk1("alt_order", gd, (k % 2) == 0);
            if (gd) chk("alt_dload", s_dload, mem[idx(32'h40)]);
            else    chk("alt_iload", s_iload, mem[3]);
        end
        dREN = 1'b0; iREN = 1'b0;
        cyc();

        // Abort: fetch dropped while RAM is BUSY
        do_reset();
        iREN = 1'b1; iaddr = 32'h10; stuck = 1'b1;
        cyc(); cyc(); cyc();
        chk1("abort_driving", s_ren, 1'b1);
        iREN = 1'b0;
        cyc();
        chk1("abort_released", s_ren, 1'b0);
        any = 1'b0;
        for (int k = 0; k < 4; k++) begin cyc(); any |= s_ihit; end
        chk1("abort_no_ihit", any, 1'b0);
        chk("abort_icnt", s_icnt, 32'd0); chk1("abort_no_err", s_err, 1'b0);
        stuck = 1'b0;

        // Saturation of the 2-bit dhit counter
        do_reset();
        for (int k = 0; k < 4; k++) begin
            dREN = 1'b1; daddr = rand_addr(); fixed_lat = k;
            wait_hit(10, gi, gd, n);
            chk1("sat_is_d", gd, 1'b1); chk("sat_dload", s_dload, mem[idx(daddr)]);
            dREN = 1'b0;
            cyc();
            chk("sat_dcnt", s_dcnt, sat(k + 1));
        end

        // Timeout: RAM stuck BUSY
        do_reset();
        dREN = 1'b1; daddr = 32'h80; stuck = 1'b1; fixed_lat = 0;
        n = 0; any = 1'b0; s_err = 1'b0; ren_at_err = 1'b1;
        while (!s_err && n < 30) begin
            cyc(); n++; any |= s_dhit;
            if (s_err) ren_at_err = s_ren;
        end
        chk1("to_err", s_err, 1'b1); chk1("to_no_dhit", any, 1'b0);
        chk1("to_cycles", (n >= 16) && (n <= 18), 1'b1);
        chk1("to_back_idle", ren_at_err, 1'b0);
        stuck = 1'b0;
        wait_hit(8, gi, gd, n);
        chk1("to_retry_dhit", gd, 1'b1); chk("to_retry_dload", s_dload, mem[idx(32'h80)]);
        chk1("to_err_sticky", s_err, 1'b1);
        dREN = 1'b0;
        cyc();

        // RAM ERROR response
        do_reset();
        #1;
        chk1("err_cleared", mem_err, 1'b0);
        dREN = 1'b1; daddr = 32'h84; err_mode = 1'b1;
        n = 0; any = 1'b0; s_err = 1'b0;
        while (!s_err && n < 6) begin cyc(); n++; any |= s_dhit; end
        chk1("ramerr_err", s_err, 1'b1); chk1("ramerr_no_dhit", any, 1'b0);
        err_mode = 1'b0;
        wait_hit(8, gi, gd, n);
        chk1("ramerr_retry", gd, 1'b1);
        dREN = 1'b0;
        cyc();

        // Randomized traffic against the transaction model
        do_reset();
        rand_lat = 1'b1;
        mi = 0; md = 0; i_act = 1'b0; d_act = 1'b0; owed = 1'b0;
        i_age = 0; d_age = 0; max_age = 0; exp_dload = 32'd0;
        for (int c = 0; c < 600; c++) begin
            cyc();
            chk1("r_exclusive", s_ihit & s_dhit, 1'b0);
            chk("r_icnt", s_icnt, sat(mi));
            chk("r_dcnt", s_dcnt, sat(md));
            chk1("r_no_err", s_err, 1'b0);
            if (s_wen) begin
                chk("r_wr_addr", s_raddr, daddr);
                chk("r_wr_data", s_rstore, dstore);
            end
            if (s_ihit) begin
                chk1("r_i_expected", i_act, 1'b1);
                chk("r_iload", s_iload, mem[idx(iaddr)]);
                i_act = 1'b0; iREN = 1'b0; owed = 1'b0; mi++;
            end
            if (s_dhit) begin
                chk1("r_d_expected", d_act, 1'b1);
                chk1("r_alternation", owed, 1'b0);
                if (dWEN) chk("r_wr_mem", mem[idx(daddr)], dstore);
                else      exp_dload = mem[idx(daddr)];
                chk("r_dload", s_dload, exp_dload);
                owed = iREN;
                d_act = 1'b0; dREN = 1'b0; dWEN = 1'b0; md++;
            end
            if (i_act) i_age++;
            if (d_act) d_age++;
            if (i_age > max_age) max_age = i_age;
            if (d_age > max_age) max_age = d_age;
            if (!i_act && ($urandom_range(0, 3) == 0)) begin
                i_act = 1'b1; iREN = 1'b1; iaddr = rand_addr(); i_age = 0;
            end
            if (!d_act && ($urandom_range(0, 3) == 0)) begin
                int kind;
                kind = int'($urandom_range(0, 2));
                d_act = 1'b1; d_age = 0;
                dREN = (kind != 1); dWEN = (kind != 0);
                daddr = rand_addr(); dstore = $urandom();
            end
        end
        chk1("r_no_starvation", max_age <= 40, 1'b1);
        chk1("r_traffic_seen", (mi > 10) && (md > 10), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder side of the datapath memory interface. It generates the ihit/dhit strobes that the pipeline registers advance on.
- Arbitrates instruction-fetch and data requests onto a single-ported RAM and returns load data.
- Sits between the datapath (fetch and memory stages) and the RAM model.
- Data requests have priority; an alternation guard prevents fetch starvation.

Parameters:
TIMEOUT, 16, max cycles the FSM waits for ramstate==ACCESS before aborting an access
CNT_W, 16, width of the saturating hit counters

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
iREN  in  1  instruction read request, held until ihit
iaddr  in  32  instruction address
dREN  in  1  data read request, held until dhit
dWEN  in  1  data write request, held until dhit
daddr  in  32  data address
dstore  in  32  data store value
ihit  out  1  one-cycle instruction response strobe
dhit  out  1  one-cycle data response strobe
iload  out  32  fetched instruction, valid while ihit=1
dload  out  32  loaded data, valid while dhit=1 (held unchanged on writes)
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
mem_err  out  1  sticky error flag (timeout or ERROR)
ihit_cnt  out  CNT_W  saturating count of ihit pulses
dhit_cnt  out  CNT_W  saturating count of dhit pulses

Behaviour:
- Reset (async, nRST=0): state IDLE; all outputs 0; iload/dload 0; wait counter 0; last_was_d 0. A reset mid-access drops the access immediately; no hit is issued.
- States: IDLE, DACC, IACC, RESP_I, RESP_D.
- IDLE, request selection:
  - If (dREN|dWEN) and !(iREN & last_was_d), go to DACC.
  - Else if iREN, go to IACC.
  - Else stay in IDLE.
- DACC:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN; ramREN=dREN&!dWEN. A write wins if both are asserted.
- IACC:
  - ramaddr=iaddr, ramREN=1, ramWEN=0.
- RAM outputs in IDLE/RESP states: all 0.
- Completion in DACC/IACC: on ramstate==ACCESS, capture ramload into dload (data reads only) or iload, then go to RESP_D/RESP_I.
- RESP_D / RESP_I:
  - Assert dhit or ihit for exactly one cycle; increment the matching counter, saturating at all-ones.
  - Set last_was_d=1 on RESP_D, 0 on RESP_I.
  - Go to IDLE.
- Latency: request sampled in IDLE at cycle t; RAM driven from t+1. If ACCESS arrives at cycle t+1+k (k>=0), the hit is at t+2+k. Minimum 2 cycles; the next request is accepted at t+3+k.
- Abort: if the active request deasserts while in DACC/IACC, return to IDLE next cycle with no hit and the counter unchanged.
- Wait counter:
  - Cleared on entry to DACC/IACC; increments each cycle without ACCESS.
  - When the counter reaches TIMEOUT, or ramstate==ERROR, set mem_err=1 and go to IDLE with no hit. The requester retries.
  - mem_err clears only on reset.
- Alternation: after a data response, a pending iREN is served before the next data request. Consecutive data requests are served back-to-back only when iREN=0.
- load registers hold their value outside hit cycles; consumers must sample only on the hit.
- ihit and dhit are never asserted in the same cycle.

Decomposition:
- cpu_types_pkg gains:
  - ramstate_t enum (FREE, BUSY, ACCESS, ERROR), if not already present
  - arb_state_t enum (IDLE, DACC, IACC, RESP_I, RESP_D)
  - word_t reused for the 32-bit buses
- One sub-module: sat_counter (parameter W; inputs CLK, nRST, inc; output count; saturates at all-ones). Instantiated twice.

Test Plan:
- Reset mid-access: iREN=1, iaddr=0x0, RAM in BUSY; deassert nRST in IACC → outputs 0, state IDLE, no ihit after release until a new access completes.
- Simple fetch: iREN=1, iaddr=0x4, ACCESS on first RAM cycle with ramload=0x8C220000 → ihit pulses at t+2 with iload=0x8C220000, ihit_cnt=1.
- Data write priority:
  - Stimulus: iREN=1 and dWEN=1 together, daddr=0x100, dstore=0xDEADBEEF.
  - Response: ramWEN with 0x100/0xDEADBEEF first; dhit, then the fetch's ihit; dload unchanged.
- Alternation: dREN held continuously with iREN=1 → response order dhit, ihit, dhit, ihit; never two dhits back-to-back.
- Timeout: dREN=1, ramstate stuck BUSY for 16 cycles → mem_err=1, no dhit, FSM returns to IDLE. A later ACCESS gives a normal dhit; mem_err stays 1.
- Abort and saturation:
  - Drop iREN during IACC → no ihit, ihit_cnt unchanged.
  - With CNT_W=2, four dhits → dhit_cnt stays 3.
